// File: rtl/timestamp_fifo_arbiter.sv
// Round-robin merge of N first-word-fall-through timestamp FIFOs into one
// registered output word, with a per-grant burst limit.
module timestamp_fifo_arbiter #(
    parameter int unsigned N         = 4,
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned SW        = 2
) (
    input  logic            BUS_CLK,
    input  logic            BUS_RST,
    input  logic [N-1:0]    SRC_EMPTY,
    input  logic [32*N-1:0] SRC_DATA,
    output logic [N-1:0]    SRC_READ,
    input  logic [N-1:0]    ENABLE,
    input  logic            OUT_READ,
    output logic            OUT_EMPTY,
    output logic [31:0]     OUT_DATA,
    output logic [SW-1:0]   OUT_SRC
);

    typedef enum logic {IDLE, STREAM} state_e;

    state_e        state_q, state_d;
    logic [SW-1:0] grant_q, grant_d;
    logic [7:0]    burst_q, burst_d;
    logic          valid_q, valid_d;
    logic [31:0]   data_q, data_d;
    logic [SW-1:0] src_q, src_d;

    logic [N-1:0]  req;
    logic          slot;
    logic          keep;
    logic          found;
    logic [SW-1:0] sel;
    logic [31:0]   sel_data;

    assign req  = ~SRC_EMPTY & ENABLE;
    assign slot = ~valid_q | OUT_READ;
    assign keep = (state_q == STREAM) && req[grant_q] && (burst_q < 8'(MAX_BURST));

    // Search order grant+1 .. grant (current grant considered last).
    always_comb begin
        int unsigned   idx;
        logic [SW-1:0] cand;
        idx   = 0;
        cand  = '0;
        found = 1'b0;
        sel   = grant_q;
        if (keep) begin
            found = 1'b1;
        end else begin
            for (int unsigned off = 1; off <= N; off++) begin
                idx  = (32'(grant_q) + off) % N;
                cand = SW'(idx);
                if (!found && req[cand]) begin
                    found = 1'b1;
                    sel   = cand;
                end
            end
        end
    end

    // Constant-index mux keeps unselected (possibly X) heads out of the datapath.
    always_comb begin
        sel_data = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (sel == SW'(k)) begin
                sel_data = SRC_DATA[32*k +: 32];
            end
        end
    end

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            state_q <= IDLE;
            grant_q <= '0;
            burst_q <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            src_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            burst_q <= burst_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            src_q   <= src_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        burst_d = burst_q;
        valid_d = valid_q;
        data_d  = data_q;
        src_d   = src_q;
        if (slot) begin
            if (found) begin
                state_d = STREAM;
                grant_d = sel;
                burst_d = keep ? burst_q + 8'd1 : 8'd1;
                valid_d = 1'b1;
                data_d  = sel_data;
                src_d   = sel;
            end else begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        end
    end

    always_comb begin
        SRC_READ = '0;
        if (slot && found && !BUS_RST) begin
            SRC_READ[sel] = 1'b1;
        end
    end

    assign OUT_EMPTY = ~valid_q;
    assign OUT_DATA  = data_q;
    assign OUT_SRC   = src_q;

endmodule
